// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared enums for the SDRAM port arbiter
package sdram_arb_pkg;

    typedef enum logic {
        RR    = 1'b0,
        FIXED = 1'b1
    } arb_mode_t;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/arb_pick.sv
// rtl/arb_pick.sv - picks one pending channel, round-robin after ptr or lowest index
module arb_pick
    import sdram_arb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int PTR_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] pending,
    input  logic [PTR_W-1:0]  ptr,
    input  arb_mode_t         mode,
    output logic [NUM_CH-1:0] winner,
    output logic              valid
);

    always_comb begin
        int  idx;
        logic found;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        // RR walks ptr+1, ptr+2, ... wrapping; FIXED walks 0, 1, ...
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (mode == FIXED) ? k : (int'(ptr) + 1 + k) % NUM_CH;
            if (!found && pending[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    assign valid = |pending;

endmodule

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - toggle-handshake arbiter sharing one SDRAM port among NUM_CH clients
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int        NUM_CH   = 4,
    parameter int        ADDR_W   = 27,
    parameter int        DATA_W   = 64,
    parameter arb_mode_t ARB_MODE = RR
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CH-1:0][ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH-1:0][15:0]       ch_din,
    input  logic [NUM_CH-1:0][1:0]        ch_be,
    input  logic [NUM_CH-1:0]             ch_rnw,
    input  logic [NUM_CH-1:0]             ch_req,
    output logic [NUM_CH-1:0]             ch_ack,
    output logic [NUM_CH-1:0][DATA_W-1:0] ch_dout,
    output logic [ADDR_W-1:0]             sdr_addr,
    output logic [15:0]                   sdr_din,
    output logic [1:0]                    sdr_be,
    output logic                          sdr_rnw,
    output logic                          sdr_req,
    input  logic                          sdr_ack,
    input  logic [DATA_W-1:0]             sdr_dout,
    output logic                          busy,
    output logic [$clog2(NUM_CH)-1:0]     grant_ch
);

    localparam int GW = $clog2(NUM_CH);

    arb_state_t                    state_q, state_d;
    logic                          sdr_req_q, sdr_req_d;
    logic [ADDR_W-1:0]             sdr_addr_q, sdr_addr_d;
    logic [15:0]                   sdr_din_q, sdr_din_d;
    logic [1:0]                    sdr_be_q, sdr_be_d;
    logic                          sdr_rnw_q, sdr_rnw_d;
    logic [GW-1:0]                 grant_q, grant_d;
    logic [NUM_CH-1:0]             ch_ack_q, ch_ack_d;
    logic [NUM_CH-1:0][DATA_W-1:0] ch_dout_q, ch_dout_d;

    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] winner;
    logic              pick_valid;
    logic [GW-1:0]     win_idx;
    logic              sdr_idle;

    assign pending  = ch_req ^ ch_ack_q;
    // A stale completion after reset leaves sdr_ack != sdr_req; we must wait it out.
    assign sdr_idle = (sdr_ack == sdr_req_q);

    arb_pick #(
        .NUM_CH (NUM_CH),
        .PTR_W  (GW)
    ) u_pick (
        .pending (pending),
        .ptr     (grant_q),
        .mode    (ARB_MODE),
        .winner  (winner),
        .valid   (pick_valid)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (winner[i]) win_idx = GW'(i);
        end
    end

    always_comb begin
        state_d    = state_q;
        sdr_req_d  = sdr_req_q;
        sdr_addr_d = sdr_addr_q;
        sdr_din_d  = sdr_din_q;
        sdr_be_d   = sdr_be_q;
        sdr_rnw_d  = sdr_rnw_q;
        grant_d    = grant_q;
        ch_ack_d   = ch_ack_q;
        ch_dout_d  = ch_dout_q;
        case (state_q)
            IDLE: begin
                if (pick_valid && sdr_idle) begin
                    state_d    = WAIT;
                    sdr_req_d  = ~sdr_req_q;
                    sdr_addr_d = ch_addr[win_idx];
                    sdr_din_d  = ch_din[win_idx];
                    sdr_be_d   = ch_be[win_idx];
                    sdr_rnw_d  = ch_rnw[win_idx];
                    grant_d    = win_idx;
                end
            end
            WAIT: begin
                if (sdr_idle) begin
                    state_d = IDLE;
                    if (sdr_rnw_q) ch_dout_d[grant_q] = sdr_dout;
                    ch_ack_d[grant_q] = ~ch_ack_q[grant_q];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            sdr_req_q  <= 1'b0;
            sdr_addr_q <= '0;
            sdr_din_q  <= '0;
            sdr_be_q   <= '0;
            sdr_rnw_q  <= 1'b1;
            grant_q    <= GW'(NUM_CH - 1);
            ch_ack_q   <= '0;
            ch_dout_q  <= '0;
        end else begin
            state_q    <= state_d;
            sdr_req_q  <= sdr_req_d;
            sdr_addr_q <= sdr_addr_d;
            sdr_din_q  <= sdr_din_d;
            sdr_be_q   <= sdr_be_d;
            sdr_rnw_q  <= sdr_rnw_d;
            grant_q    <= grant_d;
            ch_ack_q   <= ch_ack_d;
            ch_dout_q  <= ch_dout_d;
        end
    end

    assign ch_ack   = ch_ack_q;
    assign ch_dout  = ch_dout_q;
    assign sdr_addr = sdr_addr_q;
    assign sdr_din  = sdr_din_q;
    assign sdr_be   = sdr_be_q;
    assign sdr_rnw  = sdr_rnw_q;
    assign sdr_req  = sdr_req_q;
    assign busy     = (state_q == WAIT);
    assign grant_ch = grant_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - directed vector bench for sdram_port_arbiter (RR and FIXED instances)
module tb_sdram_port_arbiter;
    import sdram_arb_pkg::*;

    localparam int NC  = 4;
    localparam int AW  = 27;
    localparam int DW  = 64;
    localparam int LAT = 6;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [NC-1:0][AW-1:0] ch_addr;
    logic [NC-1:0][15:0]   ch_din;
    logic [NC-1:0][1:0]    ch_be;
    logic [NC-1:0]         ch_rnw;

    logic [NC-1:0]         ch_req   [2];
    logic [NC-1:0]         ch_ack   [2];
    logic [NC-1:0][DW-1:0] ch_dout  [2];
    logic [AW-1:0]         sdr_addr [2];
    logic [15:0]           sdr_din  [2];
    logic [1:0]            sdr_be   [2];
    logic                  sdr_rnw  [2];
    logic                  sdr_req  [2];
    logic                  sdr_ack  [2];
    logic [DW-1:0]         sdr_dout [2];
    logic                  busy     [2];
    logic [1:0]            grant_ch [2];

    sdram_port_arbiter #(.NUM_CH(NC), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(RR)) u_rr (
        .clk(clk), .reset(reset), .ch_addr(ch_addr), .ch_din(ch_din), .ch_be(ch_be),
        .ch_rnw(ch_rnw), .ch_req(ch_req[0]), .ch_ack(ch_ack[0]), .ch_dout(ch_dout[0]),
        .sdr_addr(sdr_addr[0]), .sdr_din(sdr_din[0]), .sdr_be(sdr_be[0]), .sdr_rnw(sdr_rnw[0]),
        .sdr_req(sdr_req[0]), .sdr_ack(sdr_ack[0]), .sdr_dout(sdr_dout[0]),
        .busy(busy[0]), .grant_ch(grant_ch[0])
    );

    sdram_port_arbiter #(.NUM_CH(NC), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(FIXED)) u_fix (
        .clk(clk), .reset(reset), .ch_addr(ch_addr), .ch_din(ch_din), .ch_be(ch_be),
        .ch_rnw(ch_rnw), .ch_req(ch_req[1]), .ch_ack(ch_ack[1]), .ch_dout(ch_dout[1]),
        .sdr_addr(sdr_addr[1]), .sdr_din(sdr_din[1]), .sdr_be(sdr_be[1]), .sdr_rnw(sdr_rnw[1]),
        .sdr_req(sdr_req[1]), .sdr_ack(sdr_ack[1]), .sdr_dout(sdr_dout[1]),
        .busy(busy[1]), .grant_ch(grant_ch[1])
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] dfn(input logic [AW-1:0] a);
        if (a == 27'h0001000) return 64'h1122334455667788;
        return {32'hD00DF00D, 5'b0, a};
    endfunction

    // Downstream memory: answers a toggle LAT negedges after it first sees it
    int cnt [2];
    initial begin
        for (int k = 0; k < 2; k++) begin
            sdr_ack[k] = 1'b0; sdr_dout[k] = '0; cnt[k] = 0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (sdr_req[k] != sdr_ack[k]) begin
                    cnt[k]++;
                    if (cnt[k] == LAT) begin
                        sdr_ack[k]  = sdr_req[k];
                        sdr_dout[k] = dfn(sdr_addr[k]);
                        cnt[k]      = 0;
                    end
                end
            end
        end
    end

    typedef struct {
        logic [1:0]    ch;
        logic          rnw;
        logic [AW-1:0] addr;
        logic [15:0]   din;
        logic [1:0]    be;
        logic [63:0]   exp_dout;
    } vec_t;
    vec_t vecs [6];

    task automatic do_vec(input vec_t v);
        int c, n;
        logic [NC-1:0] ack0, exp_ack;
        logic exp_req;
        c = int'(v.ch);
        ch_addr[c] = v.addr; ch_din[c] = v.din; ch_be[c] = v.be; ch_rnw[c] = v.rnw;
        ack0    = ch_ack[0];
        exp_req = ~sdr_req[0];
        exp_ack = ack0 ^ (4'b0001 << c);
        ch_req[0][c] = ~ch_req[0][c];
        @(negedge clk);
        chk("grant_latency", sdr_req[0], exp_req);
        chk("busy_wait", busy[0], 1);
        chk("grant_ch", grant_ch[0], v.ch);
        chk("sdr_addr", sdr_addr[0], v.addr);
        chk("sdr_din", sdr_din[0], v.din);
        chk("sdr_be", sdr_be[0], v.be);
        chk("sdr_rnw", sdr_rnw[0], v.rnw);
        ch_addr[c] = AW'($urandom); ch_din[c] = 16'($urandom);
        ch_be[c] = ~v.be; ch_rnw[c] = ~v.rnw;
        n = 0;
        while (ch_ack[0] == ack0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("done_cycles", n, LAT);
        chk("ch_ack", ch_ack[0], exp_ack);
        chk("ch_dout", ch_dout[0][c], v.exp_dout);
        chk("addr_held", sdr_addr[0], v.addr);
        chk("din_held", sdr_din[0], v.din);
        chk("busy_idle", busy[0], 0);
    endtask

    int exp_g [8];
    int retog [4];

    task automatic run_seq(input int k, input logic [NC-1:0] start, input int n_exp);
        int g, gap, cyc;
        logic prev_req;
        logic [NC-1:0] prev_ack, chg;
        g = 0; gap = 0; cyc = 0;
        prev_req = sdr_req[k];
        prev_ack = ch_ack[k];
        ch_req[k] = ch_req[k] ^ start;
        while (cyc < 300 && !(g == n_exp && ch_ack[k] == ch_req[k])) begin
            @(negedge clk);
            cyc++; gap++;
            if (sdr_req[k] != prev_req) begin
                if (g < n_exp) chk("seq_grant", grant_ch[k], exp_g[g]);
                else chk("seq_extra_grant", g, n_exp);
                if (g > 0) chk("seq_gap", gap, LAT + 1);
                gap = 0; g++;
                prev_req = sdr_req[k];
            end
            if (ch_ack[k] != prev_ack) begin
                chg = ch_ack[k] ^ prev_ack;
                chk("one_ack_per_cycle", $countones(chg), 1);
                for (int c = 0; c < NC; c++) begin
                    if (chg[c] && retog[c] > 0) begin
                        ch_req[k][c] = ~ch_req[k][c];
                        retog[c]--;
                    end
                end
                prev_ack = ch_ack[k];
            end
        end
        chk("seq_grants", g, n_exp);
        chk("seq_drained", ch_ack[k] == ch_req[k], 1);
    endtask

    initial begin
        int n;
        logic r0, exp_r, ack3, bad_ack;
        vec_t pre;

        vecs[0] = '{2'd2, 1'b1, 27'h0001000, 16'h0000, 2'b11, 64'h1122334455667788};
        vecs[1] = '{2'd1, 1'b0, 27'h0000200, 16'hBEEF, 2'b01, 64'h0000000000000000};
        vecs[2] = '{2'd0, 1'b1, 27'h0000040, 16'h0000, 2'b11, 64'hD00DF00D00000040};
        vecs[3] = '{2'd1, 1'b1, 27'h7FFFFFF, 16'h0000, 2'b11, 64'hD00DF00D07FFFFFF};
        vecs[4] = '{2'd1, 1'b0, 27'h0000010, 16'h1234, 2'b10, 64'hD00DF00D07FFFFFF};
        vecs[5] = '{2'd3, 1'b1, 27'h0000000, 16'h5555, 2'b00, 64'hD00DF00D00000000};

        reset = 1'b1;
        ch_addr = '0; ch_din = '0; ch_be = '0; ch_rnw = '1;
        ch_req[0] = '0; ch_req[1] = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 2; k++) begin
            chk("rst_sdr_req", sdr_req[k], 0);
            chk("rst_ch_ack", ch_ack[k], 0);
            chk("rst_ch_dout", |ch_dout[k], 0);
            chk("rst_sdr_addr", sdr_addr[k], 0);
            chk("rst_sdr_din", sdr_din[k], 0);
            chk("rst_sdr_be", sdr_be[k], 0);
            chk("rst_sdr_rnw", sdr_rnw[k], 1);
            chk("rst_grant_ch", grant_ch[k], 3);
            chk("rst_busy", busy[k], 0);
        end

        for (int i = 0; i < 6; i++) do_vec(vecs[i]);

        // All four channels kept pending: rotation 0..3 twice
        for (int i = 0; i < 8; i++) exp_g[i] = i % 4;
        for (int c = 0; c < NC; c++) retog[c] = 1;
        run_seq(0, 4'b1111, 8);

        // FIXED: ch0 re-requests twice and starves ch3
        exp_g[0] = 0; exp_g[1] = 0; exp_g[2] = 0; exp_g[3] = 3;
        retog[0] = 2; retog[1] = 0; retog[2] = 0; retog[3] = 0;
        run_seq(1, 4'b1001, 4);

        // ch3 double-toggles and ch1 re-requests while ch1 is in service
        r0 = sdr_req[0];
        exp_r = ~r0;
        ack3 = ch_ack[0][3];
        ch_req[0][1] = ~ch_req[0][1];
        @(negedge clk);
        chk("dt_grant_req", sdr_req[0], exp_r);
        chk("dt_grant_ch", grant_ch[0], 1);
        ch_req[0][3] = ~ch_req[0][3];
        ch_req[0][1] = ~ch_req[0][1];
        @(negedge clk);
        ch_req[0][3] = ~ch_req[0][3];
        n = 0;
        while (busy[0] && n < 30) begin @(negedge clk); n++; end
        @(negedge clk);
        chk("rereq_grant_req", sdr_req[0], r0);
        chk("rereq_grant_ch", grant_ch[0], 1);
        n = 0;
        while (busy[0] && n < 30) begin @(negedge clk); n++; end
        repeat (12) @(negedge clk);
        chk("dt_no_new_req", sdr_req[0], r0);
        chk("dt_ch3_ack", ch_ack[0][3], ack3);
        chk("dt_idle", busy[0], 0);

        // Reset in the middle of an access whose sdr_req is the 1->0 toggle
        if (sdr_req[0] == 1'b0) begin
            pre = '{2'd0, 1'b1, 27'h0000040, 16'h0000, 2'b11, 64'hD00DF00D00000040};
            do_vec(pre);
        end
        ch_addr[1] = 27'h0000123; ch_rnw[1] = 1'b1;
        ch_req[0][2] = ~ch_req[0][2];
        @(negedge clk);
        chk("mid_busy", busy[0], 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mr_sdr_req", sdr_req[0], 0);
        chk("mr_ch_ack", ch_ack[0], 0);
        chk("mr_busy", busy[0], 0);
        chk("mr_grant_ch", grant_ch[0], 3);
        chk("mr_stale_ack", sdr_ack[0], 1);
        n = 0;
        bad_ack = 1'b0;
        while (sdr_req[0] == 1'b0 && n < 30) begin
            @(negedge clk);
            n++;
            if (ch_ack[0] != '0) bad_ack = 1'b1;
        end
        chk("mr_wait_cycles", n, 3);
        chk("mr_no_ch_ack", bad_ack, 0);
        n = 0;
        while (ch_ack[0] != ch_req[0] && n < 200) begin @(negedge clk); n++; end
        chk("mr_drained", ch_ack[0] == ch_req[0], 1);
        chk("mr_ch1_dout", ch_dout[0][1], 64'hD00DF00D00000123);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sdram_port_arbiter.md
SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning client channel count, legal range 2..8.
REQ-002 SHALL have parameter ADDR_W, default 27, meaning byte address width.
REQ-003 SHALL have parameter DATA_W, default 64, meaning read data width returned per access.
REQ-004 SHALL have parameter ARB_MODE, default RR, meaning RR (round-robin) or FIXED (channel 0 highest).
REQ-005 SHALL have clk, input, 1, the single clock; all logic rises on clk.
REQ-006 SHALL have reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have ch_addr, input, NUM_CH x ADDR_W, per-channel address.
REQ-008 SHALL have ch_din, input, NUM_CH x 16, per-channel write data.
REQ-009 SHALL have ch_be, input, NUM_CH x 2, per-channel byte enables.
REQ-010 SHALL have ch_rnw, input, NUM_CH, per-channel direction: 1 read, 0 write.
REQ-011 SHALL have ch_req, input, NUM_CH, per-channel toggle request.
REQ-012 SHALL have ch_ack, output, NUM_CH, per-channel toggle acknowledge.
REQ-013 SHALL have ch_dout, output, NUM_CH x DATA_W, per-channel registered read data.
REQ-014 SHALL have sdr_addr, sdr_din, sdr_be, sdr_rnw, outputs, ADDR_W/16/2/1, downstream command.
REQ-015 SHALL have sdr_req, output, 1, and sdr_ack, input, 1, downstream toggle handshake.
REQ-016 SHALL have sdr_dout, input, DATA_W, downstream read data, valid when sdr_ack equals sdr_req.
REQ-017 SHALL have busy, output, 1, high when not in IDLE; grant_ch, output, clog2(NUM_CH), last granted channel.

Function
REQ-018 SHALL treat channel i pending when ch_req[i] != ch_ack[i]; pending is evaluated combinationally only in IDLE.
REQ-019 SHALL implement states IDLE, WAIT; IDLE->WAIT when any channel pending and sdr_ack == sdr_req; WAIT->IDLE when sdr_ack == sdr_req.
REQ-020 SHALL on IDLE->WAIT edge latch winner's addr/din/be/rnw onto sdr_* outputs, toggle sdr_req, set grant_ch.
REQ-021 SHALL on WAIT->IDLE edge write sdr_dout into ch_dout[grant_ch] (reads only; writes leave ch_dout unchanged) and toggle ch_ack[grant_ch] in the same edge.
REQ-022 SHALL give 1-cycle grant latency: pending seen in cycle N -> sdr_req toggles at end of cycle N.
REQ-023 SHALL spend exactly one IDLE cycle between consecutive accesses; back-to-back throughput = downstream latency + 1 cycles.
REQ-024 RR mode SHALL search from grant_ch+1 upward with wrap-around modulo NUM_CH; after reset search starts at channel 0.
REQ-025 FIXED mode SHALL grant lowest-index pending channel; starvation is permitted.
REQ-026 SHALL hold sdr_* command outputs stable throughout WAIT.
REQ-027 SHALL ignore ch_req changes of non-granted channels during WAIT except as evaluated at next IDLE; a double toggle before grant cancels the request.
REQ-028 SHALL ignore ch_req changes of the granted channel during WAIT; the new request is seen at next IDLE.
REQ-029 SHALL never toggle more than one ch_ack bit per cycle.

Reset
REQ-030 SHALL on reset set state IDLE, sdr_req 0, ch_ack all 0, ch_dout all 0, sdr_addr/din/be 0, sdr_rnw 1, grant_ch NUM_CH-1, busy 0.
REQ-031 SHALL, after reset mid-access, issue no new request until sdr_ack == sdr_req (stale downstream completion absorbed in IDLE).
REQ-032 SHALL treat channels whose ch_req is 1 at reset release as pending.

Structure
REQ-033 SHALL place arb_mode_t (RR, FIXED) and arb_state_t (IDLE, WAIT) in shared package sdram_arb_pkg.
REQ-034 SHALL implement winner selection in sub-module arb_pick (pending vector, pointer, mode -> one-hot winner, valid).

Verification
REQ-035 Single read: ch2 toggles req, addr 0x0001000, downstream returns 0x1122334455667788 after 6 cycles -> sdr_req toggles next edge, ch_dout[2]=0x1122334455667788, ch_ack[2] toggles once.
REQ-036 RR fairness: all 4 channels pending continuously -> grant order 0,1,2,3,0,1 with one IDLE cycle each.
REQ-037 FIXED mode: ch0 and ch3 pending repeatedly -> ch0 always wins; ch3 served only when ch0 idle.
REQ-038 Write: ch1 rnw=0, din 0xBEEF, be 2'b01 -> sdr_din=0xBEEF, sdr_be=01, ch_dout[1] unchanged, ch_ack[1] toggles.
REQ-039 Reset mid-WAIT then late sdr_ack toggle -> no ch_ack toggles, no new sdr_req until sdr_ack==sdr_req, then normal service.
REQ-040 Double toggle of ch3 req during another channel's WAIT -> ch3 not granted.
